// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the sprite line scheduler.
//   - Default 640x480 VGA line and frame timing, and the x/y positions that
//     start a sprite row fetch and latch sprite positions.
//   - Sprite geometry: 32x32 pixels at 1bpp, so each row is 4 ROM bytes.
//   - Fetch FSM state encoding.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_TOTAL = 800;   // pixels per line
    localparam int V_TOTAL = 525;   // lines per frame
    localparam int H_FETCH = 640;   // x at which the row fetch starts
    localparam int V_LATCH = 480;   // y at which sprite positions are latched

    localparam int SPR_DIM   = 32;  // sprite width and height in pixels
    localparam int SPR_BYTES = 4;   // ROM bytes per sprite row

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sprite_row_buf.sv
// -----------------------------------------------------------------------------
// sprite_row_buf
// One sprite's double-buffered 32-pixel row. The fetch sequencer fills the
// shadow row one byte at a time while the active row is being displayed; at
// end of line the shadow row is copied to the active row. The registered
// pixel output selects one bit of the active row.
//
// Optional feature: define SPRITE_MIRROR_EN to add the `flip` input, which
// mirrors the row horizontally.
//
// Ports:
//   clk, rst_n  pixel clock, asynchronous active-low reset
//   clr         clear the shadow row (start of a fetch sequence)
//   wr_en       write wr_data into shadow byte wr_byte (byte 0 = leftmost)
//   wr_byte     byte index within the row
//   wr_data     ROM byte, MSB is the leftmost pixel
//   swap        copy shadow row to active row
//   blank       display blanking; forces the pixel to 0
//   dx          x minus the sprite's left edge, mod 1024
//   flip        horizontal mirror (SPRITE_MIRROR_EN only)
//   pix         registered opaque bit for the current pixel
// -----------------------------------------------------------------------------
module sprite_row_buf
    import vga_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [$clog2(SPR_BYTES)-1:0] wr_byte,
    input  logic [7:0]                   wr_data,
    input  logic                         swap,
    input  logic                         blank,
    input  logic [9:0]                   dx,
`ifdef SPRITE_MIRROR_EN
    input  logic                         flip,
`endif
    output logic                         pix
);

    logic [SPR_DIM-1:0] shadow;
    logic [SPR_DIM-1:0] active;
    logic [4:0]         sel;

    // Pixel dx lives at bit 31-dx of the row; the mirror reads bit dx instead.
`ifdef SPRITE_MIRROR_EN
    assign sel = flip ? dx[4:0] : ~dx[4:0];
`else
    assign sel = ~dx[4:0];
`endif

    // NOTE: both rows are ordinary flops with an async reset so a sprite can
    // never show garbage between reset release and the first completed fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pix    <= 1'b0;
        end else begin
            if (clr) begin
                shadow <= '0;
            end else if (wr_en) begin
                // Byte b occupies bits [31-8b -: 8], i.e. base 8*(3-b).
                shadow[{~wr_byte, 3'b000} +: 8] <= wr_data;
            end
            if (swap) begin
                active <= shadow;
            end
            pix <= !blank && (dx < 10'(SPR_DIM)) && active[sel];
        end
    end

endmodule

// File: rtl/sprite_line_sched.sv
// -----------------------------------------------------------------------------
// sprite_line_sched
// Per-line sprite fetch scheduler. During horizontal blanking it walks the
// sprites, reads each visible sprite's row for the next scanline from a
// shared synchronous 1bpp ROM into a shadow buffer, and swaps all shadow rows
// to the active rows at end of line. During the visible region it emits one
// registered pixel bit per sprite (1 cycle behind x).
//
// Optional feature: define SPRITE_MIRROR_EN to add the `spr_flip` input
// (per-sprite horizontal mirror, latched with the positions).
//
// Ports:
//   CLK, RST_N      pixel clock, asynchronous active-low reset
//   x, y            current pixel counters from vga_sync
//   blank           high outside the visible area
//   spr_x, spr_y    sprite top-left positions, sprite i at [10i+9:10i]
//   spr_en          per-sprite enable
//   spr_flip        per-sprite mirror (SPRITE_MIRROR_EN only)
//   rom_addr        ROM address {id, row[4:0], byte[1:0]}
//   rom_data        ROM byte, valid 1 cycle after rom_addr
//   pix             per-sprite opaque bit, registered
//   busy            fetch sequence in progress
// -----------------------------------------------------------------------------
module sprite_line_sched #(
    parameter  int NSPR    = 2,
    parameter  int H_FETCH = vga_pkg::H_FETCH,
    parameter  int H_TOTAL = vga_pkg::H_TOTAL,
    parameter  int V_TOTAL = vga_pkg::V_TOTAL,
    parameter  int V_LATCH = vga_pkg::V_LATCH,
    localparam int AW      = $clog2(NSPR) + 7
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 blank,
    input  logic [10*NSPR-1:0]   spr_x,
    input  logic [10*NSPR-1:0]   spr_y,
    input  logic [NSPR-1:0]      spr_en,
`ifdef SPRITE_MIRROR_EN
    input  logic [NSPR-1:0]      spr_flip,
`endif
    output logic [AW-1:0]        rom_addr,
    input  logic [7:0]           rom_data,
    output logic [NSPR-1:0]      pix,
    output logic                 busy
);

    localparam int             IDW     = (NSPR > 1) ? $clog2(NSPR) : 1;
    localparam logic [9:0]     X_FETCH = 10'(H_FETCH);
    localparam logic [9:0]     X_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]     Y_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]     Y_LATCH = 10'(V_LATCH);
    localparam logic [IDW-1:0] ID_LAST = IDW'(NSPR - 1);

    // Latched sprite positions; everything downstream uses only these so a
    // mid-frame position change cannot tear the picture.
    logic [NSPR-1:0][9:0] lx;
    logic [NSPR-1:0][9:0] ly;
    logic [NSPR-1:0]      le;
`ifdef SPRITE_MIRROR_EN
    logic [NSPR-1:0]      lf;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lx <= '0;
            ly <= '0;
            le <= '0;
`ifdef SPRITE_MIRROR_EN
            lf <= '0;
`endif
        end else if (x == 10'd0 && y == Y_LATCH) begin
            lx <= spr_x;
            ly <= spr_y;
            le <= spr_en;
`ifdef SPRITE_MIRROR_EN
            lf <= spr_flip;
`endif
        end
    end

    // Target line and per-sprite row. Rows are mod 1024, so a sprite whose
    // top is above line 0 (ly near 1023) still yields the right row.
    logic [9:0]           ny;
    logic [NSPR-1:0][9:0] row;
    logic [NSPR-1:0]      on_line;

    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        ny = (y == Y_LAST) ? 10'd0 : y + 10'd1;
        for (int i = 0; i < NSPR; i++) begin
            row[i]     = ny - ly[i];
            on_line[i] = le[i] && (row[i] < 10'(vga_pkg::SPR_DIM));
        end
    end

    vga_pkg::fetch_state_e state;
    logic [IDW-1:0]        id;
    logic [1:0]            b;
    logic                  cap_valid;
    logic [IDW-1:0]        cap_id;
    logic [1:0]            cap_b;
    logic                  cur_on;
    logic [IDW+6:0]        addr_full;
    logic                  start;
    logic                  line_end;

    assign start    = (state == vga_pkg::IDLE) && (x == X_FETCH);
    assign line_end = (x == X_LAST);

    // The address is decoded straight from the FSM registers so the ROM sees
    // it in the issue cycle and its data lands exactly one cycle later.
    always_comb begin
        cur_on    = on_line[id];
        addr_full = {id, row[id][4:0], b};
        rom_addr  = (state == vga_pkg::ISSUE && cur_on) ? addr_full[AW-1:0] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= vga_pkg::IDLE;
            busy      <= 1'b0;
            id        <= '0;
            b         <= 2'd0;
            cap_valid <= 1'b0;
            cap_id    <= '0;
            cap_b     <= 2'd0;
        end else begin
            cap_valid <= 1'b0;
            unique case (state)
                vga_pkg::IDLE: begin
                    if (x == X_FETCH) begin
                        state <= vga_pkg::ISSUE;
                        busy  <= 1'b1;
                        id    <= '0;
                        b     <= 2'd0;
                    end
                end
                vga_pkg::ISSUE: begin
                    if (cur_on) begin
                        cap_valid <= 1'b1;
                        cap_id    <= id;
                        cap_b     <= b;
                        if (b == 2'd3) begin
                            b <= 2'd0;
                            if (id == ID_LAST) state <= vga_pkg::DRAIN;
                            else               id    <= id + IDW'(1);
                        end else begin
                            b <= b + 2'd1;
                        end
                    end else begin
                        // Off-line sprite: spend this cycle moving on.
                        b <= 2'd0;
                        if (id == ID_LAST) state <= vga_pkg::DRAIN;
                        else               id    <= id + IDW'(1);
                    end
                end
                vga_pkg::DRAIN: begin
                    state <= vga_pkg::IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= vga_pkg::IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // End of line always wins: the swap happens and any overrunning
            // sequence is abandoned.
            if (line_end) begin
                state <= vga_pkg::IDLE;
                busy  <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NSPR; i++) begin : g_spr
        sprite_row_buf u_buf (
            .clk     (CLK),
            .rst_n   (RST_N),
            .clr     (start),
            .wr_en   (cap_valid && (cap_id == IDW'(i))),
            .wr_byte (cap_b),
            .wr_data (rom_data),
            .swap    (line_end),
            .blank   (blank),
            .dx      (x - lx[i]),
`ifdef SPRITE_MIRROR_EN
            .flip    (lf[i]),
`endif
            .pix     (pix[i])
        );
    end

endmodule

// File: tb/tb_sprite_line_sched.sv
// -----------------------------------------------------------------------------
// tb_sprite_line_sched
// Directed bench for sprite_line_sched (NSPR=2). The bench plays vga_sync,
// driving x/y/blank directly and skipping lines it does not need. The ROM
// returns the low 8 bits of its address, so sprite id, row r, byte b reads
// back as id*128 + r*4 + b, and every expected row below is hand-computed
// from that rule.
// -----------------------------------------------------------------------------
module tb_sprite_line_sched;

    localparam int NSPR = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        blank = 1'b1;
    logic [19:0] spr_x = '0;
    logic [19:0] spr_y = '0;
    logic [1:0]  spr_en = '0;
`ifdef SPRITE_MIRROR_EN
    logic [1:0]  spr_flip = '0;
`endif
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  pix;
    logic        busy;

    sprite_line_sched #(.NSPR(NSPR)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .x        (x),
        .y        (y),
        .blank    (blank),
        .spr_x    (spr_x),
        .spr_y    (spr_y),
        .spr_en   (spr_en),
`ifdef SPRITE_MIRROR_EN
        .spr_flip (spr_flip),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix      (pix),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data = low address byte, one cycle after the address.
    always @(posedge CLK) rom_data <= rom_addr;

    int         total = 0;
    int         bad = 0;
    logic       line_pix [2][640];
    int         busy_cnt = 0;
    logic [7:0] addr_log [16];
    int         addr_n = 0;

    typedef struct {
        int          x0, y0, x1, y1;
        logic [1:0]  en;
        int          line;
        logic [31:0] w0, w1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one pixel, clock it, and sample outputs on the falling edge.
    task automatic step(input int xi, input int yi);
        x     = 10'(xi);
        y     = 10'(yi);
        blank = (xi >= 640) || (yi >= 480);
        @(posedge CLK);
        @(negedge CLK);
        if (busy) begin
            busy_cnt++;
            if (addr_n < 16) begin
                addr_log[addr_n] = rom_addr;
                addr_n++;
            end
        end
        if (xi < 640) begin
            for (int s = 0; s < NSPR; s++) line_pix[s][xi] = pix[s];
        end
    endtask

    task automatic set_cfg(input int x0, input int y0, input int x1, input int y1,
                           input logic [1:0] en);
        spr_x  = {10'(x1), 10'(x0)};
        spr_y  = {10'(y1), 10'(y0)};
        spr_en = en;
    endtask

    task automatic latch_pos();
        step(0, 480);
    endtask

    task automatic fetch_line(input int yl);
        busy_cnt = 0;
        addr_n   = 0;
        for (int xi = 640; xi < 800; xi++) step(xi, yl);
    endtask

    task automatic show_line(input int yl);
        for (int xi = 0; xi < 640; xi++) step(xi, yl);
    endtask

    // Fetch on the previous line (524 wraps to line 0), then display yl.
    task automatic run_line(input int yl);
        fetch_line((yl == 0) ? 524 : yl - 1);
        show_line(yl);
    endtask

    // Rebuild the 32-pixel row seen at left edge lx, and count every lit
    // pixel on the line so stray pixels outside the window are caught.
    task automatic check_row(input string name, input int s, input int lx,
                             input logic [31:0] exp);
        logic [31:0] got;
        int          px;
        int          ones;
        got  = '0;
        ones = 0;
        for (int d = 0; d < 32; d++) begin
            px = (lx + d) % 1024;
            if (px < 640) got[31-d] = line_pix[s][px];
        end
        for (int xi = 0; xi < 640; xi++) if (line_pix[s][xi]) ones++;
        check({name, " row"}, got, exp);
        check({name, " count"}, 32'(ones), 32'($countones(exp)));
    endtask

    logic [7:0] exp_addr [8];

    initial begin
        vecs[0] = '{50,   60,   60,   70, 2'b01, 60, 32'h00010203, 32'h00000000};
        vecs[1] = '{50,   60,   60,   70, 2'b11, 70, 32'h28292A2B, 32'h80818283};
        vecs[2] = '{50,   60,   60,   70, 2'b11, 91, 32'h7C7D7E7F, 32'hD4D5D6D7};
        vecs[3] = '{50,   60,   60,   70, 2'b11, 92, 32'h00000000, 32'hD8D9DADB};
        vecs[4] = '{50,   60,   60,   70, 2'b11, 59, 32'h00000000, 32'h00000000};
        vecs[5] = '{100, 1020, 300, 1020, 2'b01,  0, 32'h10111213, 32'h00000000};
        vecs[6] = '{100, 1020, 300, 1020, 2'b01, 27, 32'h7C7D7E7F, 32'h00000000};
        vecs[7] = '{100, 1020, 300, 1020, 2'b01, 29, 32'h00000000, 32'h00000000};
        vecs[8] = '{620,  60, 1010,   60, 2'b11, 60, 32'h00010000, 32'h00018283};

        exp_addr = '{8'h28, 8'h29, 8'h2A, 8'h2B, 8'h80, 8'h81, 8'h82, 8'h83};

        // Reset state.
        repeat (3) @(negedge CLK);
        check("reset pix", 32'(pix), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset rom_addr", 32'(rom_addr), 32'h0);
        RST_N = 1'b1;

        // Table-driven rows.
        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].en);
            latch_pos();
            run_line(vecs[i].line);
            check_row($sformatf("v%0d s0", i), 0, vecs[i].x0, vecs[i].w0);
            check_row($sformatf("v%0d s1", i), 1, vecs[i].x1, vecs[i].w1);
        end

        // Both sprites on the line: 8 reads in order, busy for 9 cycles.
        set_cfg(50, 60, 60, 70, 2'b11);
        latch_pos();
        fetch_line(69);
        check("fetch busy cycles", 32'(busy_cnt), 32'd9);
        for (int k = 0; k < 8; k++)
            check($sformatf("fetch addr %0d", k), 32'(addr_log[k]), 32'(exp_addr[k]));
        show_line(70);
        check_row("fetch s1", 1, 60, 32'h80818283);

        // Position change without a latch is ignored until the next latch.
        set_cfg(200, 60, 60, 70, 2'b11);
        run_line(75);
        check_row("no-latch s0", 0, 50, 32'h3C3D3E3F);
        latch_pos();
        run_line(75);
        check_row("relatch s0", 0, 200, 32'h3C3D3E3F);
        check_row("relatch s1", 1, 60, 32'h94959697);

        // Reset in the middle of a fetch.
        set_cfg(50, 60, 60, 70, 2'b11);
        latch_pos();
        step(640, 69);
        step(641, 69);
        step(642, 69);
        check("mid-fetch busy", 32'(busy), 32'h1);
        check("mid-fetch rom_addr", 32'(rom_addr), 32'h2A);
        RST_N = 1'b0;
        #1;
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst rom_addr", 32'(rom_addr), 32'h0);
        check("async rst pix", 32'(pix), 32'h0);
        repeat (2) @(negedge CLK);
        RST_N    = 1'b1;
        busy_cnt = 0;
        for (int xi = 643; xi < 800; xi++) step(xi, 69);
        check("post-rst no fetch", 32'(busy_cnt), 32'd0);
        show_line(70);
        check_row("post-rst s0", 0, 50, 32'h00000000);
        check_row("post-rst s1", 1, 60, 32'h00000000);
        latch_pos();
        run_line(71);
        check_row("recovered s0", 0, 50, 32'h2C2D2E2F);
        check_row("recovered s1", 1, 60, 32'h84858687);

`ifdef SPRITE_MIRROR_EN
        // Mirrored sprite 0: row 0x00010203 read right-to-left.
        spr_flip = 2'b01;
        set_cfg(50, 60, 60, 70, 2'b01);
        latch_pos();
        run_line(60);
        check_row("mirror s0", 0, 50, 32'hC0408000);
        spr_flip = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
